// File: rtl/sprite_scaled_transparent.sv
// Palette-indexed sprite with power-of-two upscale, mirror and transparency; position/mode latched at frame start.
// Outputs lag hcount/vcount by exactly 4 cycles; free-running pixel pipeline with no backpressure.
module sprite_scaled_transparent #(
    parameter int    WIDTH             = 256,
    parameter int    HEIGHT            = 256,
    parameter int    PALETTE_DEPTH     = 256,
    parameter int    MAX_SCALE_LOG2    = 2,
    parameter int    TRANSPARENT_INDEX = 0,
    parameter string IMAGE_FILE        = "image.mem",
    parameter string PALETTE_FILE      = "palette.mem"
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic [1:0]  scale_in,
    input  logic        mirror_in,
    input  logic        enable_in,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        draw_valid
);
    localparam int PW   = $clog2(PALETTE_DEPTH);
    localparam int COLW = $clog2(WIDTH);
    localparam int AW   = $clog2(WIDTH * HEIGHT);
    localparam logic [COLW-1:0] COL_MAX = COLW'(WIDTH - 1);

    logic        frame_start;
    logic [1:0]  scale_clamped;
    logic [10:0] x_q, x_cur;
    logic [9:0]  y_q, y_cur;
    logic [1:0]  scale_q, scale_cur;
    logic        mirror_q, mirror_cur;
    logic        enable_q, enable_cur;

    assign frame_start   = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign scale_clamped = (int'(scale_in) > MAX_SCALE_LOG2) ? 2'(MAX_SCALE_LOG2) : scale_in;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_q      <= '0;
            y_q      <= '0;
            scale_q  <= '0;
            mirror_q <= 1'b0;
            enable_q <= 1'b0;
        end else if (frame_start) begin
            x_q      <= x_in;
            y_q      <= y_in;
            scale_q  <= scale_clamped;
            mirror_q <= mirror_in;
            enable_q <= enable_in;
        end
    end

    // The frame-start pixel itself must already see the new position/mode.
    assign x_cur      = frame_start ? x_in          : x_q;
    assign y_cur      = frame_start ? y_in          : y_q;
    assign scale_cur  = frame_start ? scale_clamped : scale_q;
    assign mirror_cur = frame_start ? mirror_in     : mirror_q;
    assign enable_cur = frame_start ? enable_in     : enable_q;

    logic [11:0]     dx, dy, dx_src, dy_src;
    logic [15:0]     box_w, box_h;
    logic            in_box;
    logic [COLW-1:0] col;
    logic [AW-1:0]   image_addr;

    assign dx     = {1'b0, hcount_in} - {1'b0, x_cur};
    assign dy     = {2'b0, vcount_in} - {2'b0, y_cur};
    assign box_w  = 16'(WIDTH) << scale_cur;
    assign box_h  = 16'(HEIGHT) << scale_cur;
    assign in_box = enable_cur && (hcount_in >= x_cur) && (vcount_in >= y_cur)
                    && ({4'b0, dx} < box_w) && ({4'b0, dy} < box_h);

    assign dx_src     = dx >> scale_cur;
    assign dy_src     = dy >> scale_cur;
    assign col        = mirror_cur ? COL_MAX - dx_src[COLW-1:0] : dx_src[COLW-1:0];
    assign image_addr = AW'((32'(dy_src) << COLW) + 32'(col));

    logic [PW-1:0] image_index;
    logic [23:0]   palette_data;

    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH      (PW),
        .RAM_DEPTH      (WIDTH * HEIGHT),
        .RAM_PERFORMANCE("HIGH_PERFORMANCE"),
        .INIT_FILE      (IMAGE_FILE)
    ) image_rom (
        .addra (image_addr),
        .dina  ('0),
        .clka  (pixel_clk_in),
        .wea   (1'b0),
        .ena   (1'b1),
        .rsta  (1'b0),
        .regcea(1'b1),
        .douta (image_index)
    );

    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH      (24),
        .RAM_DEPTH      (PALETTE_DEPTH),
        .RAM_PERFORMANCE("HIGH_PERFORMANCE"),
        .INIT_FILE      (PALETTE_FILE)
    ) palette_rom (
        .addra (image_index),
        .dina  ('0),
        .clka  (pixel_clk_in),
        .wea   (1'b0),
        .ena   (1'b1),
        .rsta  (1'b0),
        .regcea(1'b1),
        .douta (palette_data)
    );

    logic [3:0]    in_box_d;
    logic [PW-1:0] index_d3, index_d4;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            in_box_d <= '0;
            index_d3 <= '0;
            index_d4 <= '0;
        end else begin
            in_box_d <= {in_box_d[2:0], in_box};
            index_d3 <= image_index;
            index_d4 <= index_d3;
        end
    end

    assign draw_valid = in_box_d[3] && (index_d4 != PW'(TRANSPARENT_INDEX));
    assign red_out    = in_box_d[3] ? palette_data[23:16] : 8'd0;
    assign green_out  = in_box_d[3] ? palette_data[15:8]  : 8'd0;
    assign blue_out   = in_box_d[3] ? palette_data[7:0]   : 8'd0;
endmodule

// Single-port block RAM, read-first, with optional output register (2-cycle read when HIGH_PERFORMANCE).
module xilinx_single_port_ram_read_first #(
    parameter int    RAM_WIDTH       = 18,
    parameter int    RAM_DEPTH       = 1024,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter string INIT_FILE       = ""
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         ena,
    input  logic                         rsta,
    input  logic                         regcea,
    output logic [RAM_WIDTH-1:0]         douta
);
    logic [RAM_WIDTH-1:0] ram [0:RAM_DEPTH-1];
    logic [RAM_WIDTH-1:0] ram_data;

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) ram[addra] <= dina;
            ram_data <= ram[addra];
        end
    end

    // Contents come from INIT_FILE through the implementation flow's memory-init step.
    if (INIT_FILE != "") begin : g_preloaded
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_output_reg
        assign douta = ram_data;
    end else begin : g_output_reg
        always_ff @(posedge clka) begin
            if (rsta)        douta <= '0;
            else if (regcea) douta <= ram_data;
        end
    end
endmodule

// File: tb/tb_sprite_scaled_transparent.sv
// Directed plus randomized raster points checked against a pixel-level sprite model, 4-cycle aligned.
module tb_sprite_scaled_transparent;
    localparam int WIDTH = 16, HEIGHT = 8, PDEPTH = 16, MAXS = 2, TI = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [10:0] hcount, x;
    logic [9:0]  vcount, y;
    logic [1:0]  scale;
    logic        mirror, enable;
    logic [7:0]  red, green, blue;
    logic        draw_valid;

    sprite_scaled_transparent #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PALETTE_DEPTH(PDEPTH),
        .MAX_SCALE_LOG2(MAXS), .TRANSPARENT_INDEX(TI)
    ) dut (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .x_in(x), .y_in(y), .scale_in(scale), .mirror_in(mirror), .enable_in(enable),
        .red_out(red), .green_out(green), .blue_out(blue), .draw_valid(draw_valid)
    );

    typedef struct { int h; int v; logic [23:0] rgb; logic dv; } exp_t;

    logic [3:0]  img [WIDTH*HEIGHT];
    logic [23:0] pal [PDEPTH];
    int m_x, m_y, m_s;
    bit m_mir, m_en;
    exp_t expq[$];
    int vectors = 0, errors = 0;
    logic rst_level;

    function automatic exp_t model(input int h, input int v);
        exp_t e;
        int f, sx, sy;
        logic [3:0] idx;
        e.h = h; e.v = v; e.rgb = '0; e.dv = 1'b0;
        f = 1 << m_s;
        if (m_en && h >= m_x && v >= m_y && h < m_x + WIDTH * f && v < m_y + HEIGHT * f) begin
            sx = (h - m_x) / f;
            sy = (v - m_y) / f;
            if (m_mir) sx = WIDTH - 1 - sx;
            idx = img[sy * WIDTH + sx];
            e.rgb = pal[idx];
            e.dv = (int'(idx) != TI);
        end
        return e;
    endfunction

    task automatic step(input int h, input int v);
        exp_t e;
        @(negedge clk);
        if (expq.size() == 4) begin
            e = expq.pop_front();
            vectors++;
            assert ({red, green, blue} === e.rgb) else begin
                errors++;
                $error("FAIL rgb @(%0d,%0d) observed %06h expected %06h", e.h, e.v, {red, green, blue}, e.rgb);
            end
            assert (draw_valid === e.dv) else begin
                errors++;
                $error("FAIL draw_valid @(%0d,%0d) observed %b expected %b", e.h, e.v, draw_valid, e.dv);
            end
        end
        if (!rst_level && rst_n) begin
            rst_n = 1'b0;
            #1;
            vectors++;
            assert ({red, green, blue, draw_valid} === 25'd0) else begin
                errors++;
                $error("FAIL reset_blank observed %07h expected 0", {red, green, blue, draw_valid});
            end
            foreach (expq[i]) begin expq[i].rgb = '0; expq[i].dv = 1'b0; end
            m_x = 0; m_y = 0; m_s = 0; m_mir = 0; m_en = 0;
        end else if (rst_level && !rst_n) begin
            rst_n = 1'b1;
        end
        hcount = h[10:0];
        vcount = v[9:0];
        if (rst_n && h == 0 && v == 0) begin
            m_x = int'(x); m_y = int'(y); m_mir = mirror; m_en = enable;
            m_s = (int'(scale) > MAXS) ? MAXS : int'(scale);
        end
        if (rst_n) e = model(h, v);
        else begin e.h = h; e.v = v; e.rgb = '0; e.dv = 1'b0; end
        expq.push_back(e);
    endtask

    task automatic frame(input int fx, input int fy, input int fs, input bit fm, input bit fe);
        x = fx[10:0]; y = fy[9:0]; scale = fs[1:0]; mirror = fm; enable = fe;
        step(0, 0);
    endtask

    task automatic row(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) step(h, v);
    endtask

    initial begin
        rst_n = 1'b1; rst_level = 1'b0;
        hcount = 11'd5; vcount = 10'd5; x = '0; y = '0; scale = '0; mirror = 1'b0; enable = 1'b0;
        for (int i = 0; i < WIDTH * HEIGHT; i++) img[i] = 4'($urandom_range(0, 15));
        img[0] = 4'd7; img[1] = 4'd0; img[2] = 4'd0; img[3] = 4'd5; img[WIDTH-1] = 4'd9;
        for (int i = 0; i < PDEPTH; i++) pal[i] = 24'($urandom) | 24'h010101;
        for (int i = 0; i < WIDTH * HEIGHT; i++) dut.image_rom.ram[i] <= img[i];
        for (int i = 0; i < PDEPTH; i++) dut.palette_rom.ram[i] <= pal[i];
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        assert ({red, green, blue, draw_valid} === 25'd0) else begin
            errors++;
            $error("FAIL reset_state observed %07h expected 0", {red, green, blue, draw_valid});
        end
        repeat (6) step(3, 3);
        rst_level = 1'b1;

        // Basic 1x placement, including the first column/row and the right/bottom edges.
        frame(100, 50, 0, 0, 1);
        row(50, 96, 120);
        row(57, 110, 118);
        row(58, 110, 118);
        // Mid-frame x change is ignored until the next frame start.
        row(120, 10, 14);
        x = 11'd300;
        row(52, 98, 104);
        row(52, 298, 304);
        step(0, 0);
        row(52, 96, 104);
        row(52, 296, 318);

        frame(100, 50, 1, 0, 1);
        row(50, 98, 134);
        row(51, 100, 106);
        row(65, 128, 134);
        row(66, 128, 134);

        frame(100, 50, 0, 1, 1);
        row(50, 98, 118);

        frame(100, 50, 3, 0, 1);
        row(50, 96, 168);
        row(81, 160, 166);
        row(82, 160, 166);

        frame(0, 0, 0, 0, 1);
        row(0, 1, 20);
        row(7, 0, 18);

        frame(2040, 1020, 2, 0, 1);
        row(1021, 2036, 2047);
        row(1021, 0, 6);
        row(1, 1, 6);

        // Reset inside the sprite, then a disabled frame.
        frame(100, 50, 2, 0, 1);
        row(80, 100, 110);
        rst_level = 1'b0;
        row(80, 111, 114);
        rst_level = 1'b1;
        row(80, 100, 110);
        frame(100, 50, 0, 0, 0);
        row(55, 96, 120);

        for (int f = 0; f < 10; f++) begin
            int fx, fy;
            fx = (f % 2 == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 200));
            fy = (f % 3 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 100));
            frame(fx, fy, int'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 3) != 0));
            for (int k = 0; k < 200; k++) begin
                if (k % 50 == 25) begin
                    x = 11'($urandom); y = 10'($urandom); scale = 2'($urandom);
                    mirror = 1'($urandom); enable = 1'($urandom);
                end
                step((fx + int'($urandom_range(0, 80)) - 8) & 2047,
                     (fy + int'($urandom_range(0, 40)) - 4) & 1023);
            end
        end
        repeat (4) step(1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/sprite_scaled_transparent.md
Name: sprite_scaled_transparent

Overview:
- Pipelined, palette-indexed sprite renderer with transparency, and the next generation of the single-sprite BROM renderer.
- Adds integer power-of-two upscaling, horizontal mirroring, a runtime enable, and a frame-synchronous latch of position and mode so a sprite never tears mid-frame.
- Sits between the video timing generator (hcount/vcount) and the layer compositor; draw_valid tells the compositor where the sprite is opaque.

Parameters:
- WIDTH, 256, sprite width in source pixels (power of two).
- HEIGHT, 256, sprite height in source pixels.
- PALETTE_DEPTH, 256, palette entries; index width PW = $clog2(PALETTE_DEPTH).
- MAX_SCALE_LOG2, 2, largest allowed scale_in value (scale factor 1<<scale_in).
- TRANSPARENT_INDEX, 0, palette index treated as transparent.
- IMAGE_FILE, "image.mem", image BROM init file.
- PALETTE_FILE, "palette.mem", palette BROM init file.

Ports:
- pixel_clk_in  in  1  pixel clock; all logic on its rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- hcount_in  in  11  current pixel column.
- vcount_in  in  10  current pixel row.
- x_in  in  11  requested sprite left edge (screen pixels).
- y_in  in  10  requested sprite top edge.
- scale_in  in  2  requested log2 scale factor.
- mirror_in  in  1  requested horizontal mirror.
- enable_in  in  1  requested sprite visibility.
- red_out  out  8  pixel red, aligned to hcount/vcount 4 cycles earlier.
- green_out  out  8  pixel green, same alignment.
- blue_out  out  8  pixel blue, same alignment.
- draw_valid  out  1  high when the aligned pixel is inside the sprite, enabled, and not transparent.

Behaviour:
- Reset: asserting rst_n_in low asynchronously clears the following to 0:
  - latched x, y, scale, mirror and enable;
  - all pipeline valid/index registers;
  - red_out, green_out, blue_out and draw_valid.
  - BROM contents are unaffected.
  - Reset asserted mid-frame blanks output from the next cycle. After release, output stays blank until the next frame-start latch with enable_in=1.
- Frame latch: on a cycle with hcount_in==0 and vcount_in==0, the block registers x_in, y_in, mirror_in, enable_in and the clamped scale. The clamped scale is min(scale_in, MAX_SCALE_LOG2). Input changes at any other time are ignored until the next frame start. The latched values apply from the frame-start pixel itself, i.e. the pixel at (0,0) uses the new values.
- Stage 0 (combinational on inputs plus latched state; the frame-start cycle uses the newly latched values):
  - dx = hcount_in - x, dy = vcount_in - y, computed 12 bits wide.
  - in_box = enable && hcount_in>=x && vcount_in>=y && dx < (WIDTH<<s) && dy < (HEIGHT<<s). Compares are 16 bits wide, with no wrap on large x/y.
  - col = dx>>s, or WIDTH-1-(dx>>s) when mirror is set; row = dy>>s.
  - addr = row*WIDTH + col, width $clog2(WIDTH*HEIGHT). When in_box=0, addr is don't-care.
- Image BROM: xilinx_single_port_ram_read_first, RAM_WIDTH=PW, HIGH_PERFORMANCE, 2-cycle latency. Its output index addresses the palette BROM (RAM_WIDTH=24, HIGH_PERFORMANCE, 2 cycles).
- Side-band pipeline:
  - in_box goes through a 4-stage shift.
  - The palette index is delayed 2 further stages to align with the palette data.
- Outputs, driven combinationally from stage 4:
  - opaque = in_box_d4 && index_d4 != TRANSPARENT_INDEX.
  - red/green/blue = palette data [23:16]/[15:8]/[7:0] when in_box_d4, else 0.
  - draw_valid = opaque.
  - Total latency from hcount/vcount to outputs is exactly 4 cycles.
- Boundaries:
  - Sprite partially off-screen right/bottom: only on-screen pixels are produced; no wrap to column 0.
  - x=0, y=0 is legal.
  - scale_in > MAX_SCALE_LOG2 clamps.
  - Transparent pixels still output their palette colour but draw_valid=0.

Test Plan:
- Reset, then frame start with x=100, y=50, scale=0, mirror=0, enable=1 -> draw_valid first rises 4 cycles after hcount=100, vcount=50; RGB equals palette[image[0]].
- Same frame with scale=1 -> each source pixel is repeated on 2 columns and 2 rows; pixel (103,51) maps to image address 1; the box ends after hcount 100+2*WIDTH-1.
- mirror=1, scale=0 -> pixel at hcount=x maps to image address WIDTH-1; hcount=x+WIDTH-1 maps to address 0.
- Image pixel whose index==TRANSPARENT_INDEX -> RGB nonzero per palette, draw_valid=0; adjacent opaque pixel -> draw_valid=1.
- Change x_in from 100 to 300 mid-frame (vcount=120) -> the rest of the frame still renders at x=100; the next frame renders at 300. scale_in=3 with MAX_SCALE_LOG2=2 -> renders at 4x.
- Drive rst_n_in low at vcount=80 inside the sprite -> all outputs 0 on the next edge. After release, blank until the next frame start; enable_in=0 at frame start -> draw_valid never asserts that frame.
